// File: rtl/fetch_align_n_pkg.sv
// Shared definitions for the fetch-align stage: FSM encoding, width helper
// and redirect source priority order.
package fetch_align_n_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

  // Redirect sources; a lower index has higher priority.
  localparam int REDIR_INIT    = 0;
  localparam int REDIR_RESTEER = 1;
  localparam int REDIR_BP      = 2;
  localparam int REDIR_NUM     = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_align_n_byte_rot.sv
// Log-shifter byte rotator: rotates the IBuf window right by `rot` bytes and
// returns the low PKT_BYTES bytes, so byte 0 of the result is window byte rot.
module fetch_byte_rot #(
  parameter int WIN_BYTES = 64,
  parameter int ROT_W     = 6,
  parameter int PKT_BYTES = 16
) (
  input  logic [WIN_BYTES*8-1:0] win_data,
  input  logic [ROT_W-1:0]       rot,
  output logic [PKT_BYTES*8-1:0] pkt
);

  localparam int WB = WIN_BYTES * 8;

  // Stage s rotates by 2**s bytes when rot[s] is set.
  for (genvar s = 0; s < ROT_W; s++) begin : g_stage
    localparam int SH = (1 << s) * 8;
    logic [WB-1:0] in_s;
    logic [WB-1:0] out_s;
    if (s == 0) begin : g_first
      assign in_s = win_data;
    end else begin : g_next
      assign in_s = g_stage[s-1].out_s;
    end
    assign out_s = rot[s] ? {in_s[SH-1:0], in_s[WB-1:SH]} : in_s;
  end

  assign pkt = g_stage[ROT_W-1].out_s[PKT_BYTES*8-1:0];

endmodule

// File: rtl/fetch_align_n.sv
// Second fetch stage: owns the byte instruction pointer into the IBuf ring,
// presents a rotated decode packet and reports line release / flush events.
module fetch_align_n
  import fetch_align_n_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 4,
  parameter int PKT_BYTES  = 16,
  parameter int LEN_W      = 8,
  localparam int WIN_BYTES = LINE_BYTES * NUM_LINES,
  localparam int BIP_W     = clog2(WIN_BYTES),
  localparam int OFF_W     = clog2(LINE_BYTES),
  localparam int LIDX_W    = clog2(NUM_LINES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LINES*LINE_BYTES*8-1:0] line_data,
  input  logic [NUM_LINES-1:0]            line_valid,
  output logic [NUM_LINES-1:0]            line_release,
  output logic                            ibuf_flush,
  output logic [LIDX_W-1:0]               flush_line,
  input  logic                            init_valid,
  input  logic [BIP_W-1:0]                init_bip,
  input  logic                            resteer_valid,
  input  logic [BIP_W-1:0]                resteer_bip,
  input  logic                            bp_valid,
  input  logic [BIP_W-1:0]                bp_bip,
  input  logic                            dec_ready,
  input  logic [LEN_W-1:0]                dec_length,
  output logic [PKT_BYTES*8-1:0]          pkt_data,
  output logic                            pkt_valid,
  output logic [BIP_W-1:0]                pkt_old_bip,
  output logic [BIP_W-1:0]                pkt_new_bip,
  output logic                            len_err
);

  fetch_state_e          state_r;
  fetch_state_e          state_nxt_s;
  logic [BIP_W-1:0]      bip_r;
  logic [BIP_W-1:0]      target_s;
  logic [BIP_W-1:0]      adv_s;
  logic [BIP_W-1:0]      new_bip_s;
  logic [LIDX_W-1:0]     cur_line_s;
  logic [LIDX_W-1:0]     nxt_line_s;
  logic [LIDX_W-1:0]     new_line_s;
  logic [OFF_W-1:0]      off_s;
  logic [OFF_W:0]        span_end_s;
  logic                  single_s;
  logic                  covered_s;
  logic [REDIR_NUM-1:0]  redir_req_s;
  logic                  redir_s;
  logic                  run_s;
  logic                  pkt_valid_s;
  logic                  xfer_s;
  logic                  len_ok_s;
  logic [NUM_LINES-1:0]  release_s;
  logic [NUM_LINES-1:0]  line_release_r;
  logic                  ibuf_flush_r;
  logic [LIDX_W-1:0]     flush_line_r;
  logic                  len_err_r;

  assign cur_line_s = bip_r[BIP_W-1:OFF_W];
  assign off_s      = bip_r[OFF_W-1:0];
  assign nxt_line_s = cur_line_s + LIDX_W'(1);

  // A packet that ends inside the current line needs only that line.
  assign span_end_s = {1'b0, off_s} + (OFF_W+1)'(PKT_BYTES);
  assign single_s   = (span_end_s <= (OFF_W+1)'(LINE_BYTES));
  assign covered_s  = line_valid[cur_line_s] & (single_s | line_valid[nxt_line_s]);

  // Illegal lengths advance a full packet so decode can never stall the pipe.
  assign len_ok_s   = (dec_length != LEN_W'(0)) && (dec_length <= LEN_W'(PKT_BYTES));
  assign adv_s      = len_ok_s ? BIP_W'(dec_length) : BIP_W'(PKT_BYTES);
  assign new_bip_s  = bip_r + adv_s;
  assign new_line_s = new_bip_s[BIP_W-1:OFF_W];
  assign release_s  = {{(NUM_LINES-1){1'b0}}, 1'b1} << cur_line_s;

  // Redirect arbitration: IDLE listens to init only, otherwise fixed priority.
  always_comb begin
    redir_req_s = {REDIR_NUM{1'b0}};
    target_s    = bp_bip;
    redir_req_s[REDIR_INIT] = init_valid;
    if (state_r == FS_IDLE) begin
      redir_req_s[REDIR_RESTEER] = 1'b0;
      redir_req_s[REDIR_BP]      = 1'b0;
    end else begin
      redir_req_s[REDIR_RESTEER] = resteer_valid;
      redir_req_s[REDIR_BP]      = bp_valid;
    end
    if (redir_req_s[REDIR_INIT]) begin
      target_s = init_bip;
    end else if (redir_req_s[REDIR_RESTEER]) begin
      target_s = resteer_bip;
    end else begin
      target_s = bp_bip;
    end
  end

  assign redir_s = |redir_req_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FS_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (redir_s) begin
      state_nxt_s = FS_WAIT;
    end else begin
      case (state_r)
        FS_IDLE: state_nxt_s = FS_IDLE;
        FS_WAIT: state_nxt_s = covered_s ? FS_RUN : FS_WAIT;
        FS_RUN:  state_nxt_s = FS_RUN;
        default: state_nxt_s = FS_IDLE;
      endcase
    end
  end

  // FSM outputs: WAIT already presents a packet once its lines arrive, which
  // gives the one-cycle redirect-to-packet path.
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      FS_RUN, FS_WAIT: run_s = 1'b1;
      default:         run_s = 1'b0;
    endcase
    pkt_valid_s = run_s & covered_s & ~redir_s;
  end

  assign xfer_s = pkt_valid_s & dec_ready;

  // Pointer, release/flush pulses and sticky length error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bip_r          <= {BIP_W{1'b0}};
      line_release_r <= {NUM_LINES{1'b0}};
      ibuf_flush_r   <= 1'b0;
      flush_line_r   <= {LIDX_W{1'b0}};
      len_err_r      <= 1'b0;
    end else begin
      ibuf_flush_r   <= redir_s;
      flush_line_r   <= redir_s ? target_s[BIP_W-1:OFF_W] : {LIDX_W{1'b0}};
      line_release_r <= (xfer_s && (new_line_s != cur_line_s)) ? release_s : {NUM_LINES{1'b0}};
      len_err_r      <= len_err_r | (xfer_s & ~len_ok_s);
      if (redir_s) begin
        bip_r <= target_s;
      end else if (xfer_s) begin
        bip_r <= new_bip_s;
      end else begin
        bip_r <= bip_r;
      end
    end
  end

  fetch_byte_rot #(
    .WIN_BYTES (WIN_BYTES),
    .ROT_W     (BIP_W),
    .PKT_BYTES (PKT_BYTES)
  ) u_rot (
    .win_data (line_data),
    .rot      (bip_r),
    .pkt      (pkt_data)
  );

  assign pkt_valid    = pkt_valid_s;
  assign pkt_old_bip  = bip_r;
  assign pkt_new_bip  = new_bip_s;
  assign line_release = line_release_r;
  assign ibuf_flush   = ibuf_flush_r;
  assign flush_line   = flush_line_r;
  assign len_err      = len_err_r;

endmodule

// File: tb/tb_fetch_align_n.sv
// Bench for fetch_align_n: directed scenarios plus a randomized run checked
// against a byte-level model of the instruction window.
module tb_fetch_align_n;

  localparam int LB  = 16;
  localparam int NL  = 4;
  localparam int PB  = 16;
  localparam int LW  = 8;
  localparam int WIN = LB * NL;
  localparam int BW  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [NL*LB*8-1:0] ld;
  logic [NL-1:0]     lv;
  logic [NL-1:0]     line_release;
  logic              ibuf_flush;
  logic [1:0]        flush_line;
  logic              init_valid, resteer_valid, bp_valid;
  logic [BW-1:0]     init_bip, resteer_bip, bp_bip;
  logic              dec_ready;
  logic [LW-1:0]     dec_length;
  logic [PB*8-1:0]   pkt_data;
  logic              pkt_valid;
  logic [BW-1:0]     pkt_old_bip, pkt_new_bip;
  logic              len_err;

  int n_vec = 0;
  int n_err = 0;

  fetch_align_n dut (
    .clk(clk), .reset(reset), .line_data(ld), .line_valid(lv),
    .line_release(line_release), .ibuf_flush(ibuf_flush), .flush_line(flush_line),
    .init_valid(init_valid), .init_bip(init_bip),
    .resteer_valid(resteer_valid), .resteer_bip(resteer_bip),
    .bp_valid(bp_valid), .bp_bip(bp_bip),
    .dec_ready(dec_ready), .dec_length(dec_length),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .pkt_old_bip(pkt_old_bip), .pkt_new_bip(pkt_new_bip), .len_err(len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] wbyte(input int j);
    return ld[(j % WIN)*8 +: 8];
  endfunction

  function automatic logic [PB*8-1:0] exp_pkt(input int bip);
    logic [PB*8-1:0] r;
    for (int k = 0; k < PB; k++) r[k*8 +: 8] = wbyte(bip + k);
    return r;
  endfunction

  // Every byte of the packet must lie in a valid line.
  function automatic bit exp_cov(input int bip, input logic [NL-1:0] v);
    bit c;
    c = 1'b1;
    for (int k = 0; k < PB; k++) if (!v[((bip + k) % WIN) / LB]) c = 1'b0;
    return c;
  endfunction

  task automatic clear_inputs();
    init_valid = 1'b0; resteer_valid = 1'b0; bp_valid = 1'b0;
    init_bip = 6'd0; resteer_bip = 6'd0; bp_bip = 6'd0;
    dec_ready = 1'b0; dec_length = 8'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    lv = 4'b0000;
    reset = 1'b1;
    tick();
    n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL reset_pkt_valid: got %b want 0", pkt_valid); end
    n_vec++; if (line_release !== 4'b0000) begin n_err++; $display("FAIL reset_release: got %b want 0000", line_release); end
    n_vec++; if (ibuf_flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", ibuf_flush); end
    n_vec++; if (len_err !== 1'b0) begin n_err++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    n_vec++; if (pkt_old_bip !== 6'h00) begin n_err++; $display("FAIL reset_bip: got %h want 00", pkt_old_bip); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_init_redirect();
    lv = 4'b0011;
    init_valid = 1'b1; init_bip = 6'h00;
    tick();
    clear_inputs();
    #1;
    n_vec++; if (ibuf_flush !== 1'b1) begin n_err++; $display("FAIL init_flush: got %b want 1", ibuf_flush); end
    n_vec++; if (flush_line !== 2'd0) begin n_err++; $display("FAIL init_flush_line: got %0d want 0", flush_line); end
    n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL init_pkt_valid: got %b want 1", pkt_valid); end
    n_vec++; if (pkt_data[7:0] !== ld[7:0]) begin n_err++; $display("FAIL init_byte0: got %h want %h", pkt_data[7:0], ld[7:0]); end
    tick();
    n_vec++; if (ibuf_flush !== 1'b0) begin n_err++; $display("FAIL init_flush_pulse: got %b want 0", ibuf_flush); end
  endtask

  task automatic test_advance();
    lv = 4'b1111;
    init_valid = 1'b1; init_bip = 6'h0C;
    tick();
    clear_inputs();
    dec_ready = 1'b1; dec_length = 8'd6;
    #1;
    n_vec++; if (pkt_new_bip !== 6'h12) begin n_err++; $display("FAIL adv_new_bip: got %h want 12", pkt_new_bip); end
    tick();
    dec_ready = 1'b0;
    #1;
    n_vec++; if (pkt_old_bip !== 6'h12) begin n_err++; $display("FAIL adv_old_bip: got %h want 12", pkt_old_bip); end
    n_vec++; if (line_release !== 4'b0001) begin n_err++; $display("FAIL adv_release: got %b want 0001", line_release); end
    tick();
    n_vec++; if (line_release !== 4'b0000) begin n_err++; $display("FAIL adv_release_pulse: got %b want 0000", line_release); end
  endtask

  task automatic test_wrap();
    lv = 4'b1000;
    init_valid = 1'b1; init_bip = 6'h3E;
    tick();
    clear_inputs();
    #1;
    n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL wrap_uncovered: got %b want 0", pkt_valid); end
    lv = 4'b1001;
    #1;
    n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL wrap_covered: got %b want 1", pkt_valid); end
    n_vec++; if (pkt_data !== exp_pkt(62)) begin n_err++; $display("FAIL wrap_data: got %h want %h", pkt_data, exp_pkt(62)); end
    dec_ready = 1'b1; dec_length = 8'd4;
    #1;
    n_vec++; if (pkt_new_bip !== 6'h02) begin n_err++; $display("FAIL wrap_new_bip: got %h want 02", pkt_new_bip); end
    tick();
    clear_inputs();
    #1;
    n_vec++; if (pkt_old_bip !== 6'h02) begin n_err++; $display("FAIL wrap_old_bip: got %h want 02", pkt_old_bip); end
    n_vec++; if (line_release !== 4'b1000) begin n_err++; $display("FAIL wrap_release: got %b want 1000", line_release); end
  endtask

  task automatic test_redirect_priority();
    lv = 4'b1111;
    resteer_valid = 1'b1; resteer_bip = 6'h20;
    bp_valid = 1'b1; bp_bip = 6'h30;
    dec_ready = 1'b1; dec_length = 8'd4;
    #1;
    n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL prio_pkt_valid: got %b want 0", pkt_valid); end
    tick();
    clear_inputs();
    #1;
    n_vec++; if (pkt_old_bip !== 6'h20) begin n_err++; $display("FAIL prio_bip: got %h want 20", pkt_old_bip); end
    n_vec++; if (ibuf_flush !== 1'b1) begin n_err++; $display("FAIL prio_flush: got %b want 1", ibuf_flush); end
    n_vec++; if (flush_line !== 2'd2) begin n_err++; $display("FAIL prio_flush_line: got %0d want 2", flush_line); end
    n_vec++; if (line_release !== 4'b0000) begin n_err++; $display("FAIL prio_release: got %b want 0000", line_release); end
  endtask

  task automatic test_stall_len_err();
    dec_ready = 1'b0; dec_length = 8'd8;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (pkt_old_bip !== 6'h20) begin n_err++; $display("FAIL stall_bip[%0d]: got %h want 20", i, pkt_old_bip); end
      n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, pkt_valid); end
      n_vec++; if (pkt_data !== exp_pkt(32)) begin n_err++; $display("FAIL stall_data[%0d]: got %h want %h", i, pkt_data, exp_pkt(32)); end
      n_vec++; if ((line_release !== 4'b0000) || (ibuf_flush !== 1'b0)) begin n_err++; $display("FAIL stall_pulses[%0d]: got rel=%b flush=%b want 0", i, line_release, ibuf_flush); end
    end
    dec_ready = 1'b1; dec_length = 8'd0;
    #1;
    n_vec++; if (pkt_new_bip !== 6'h30) begin n_err++; $display("FAIL lenerr_new_bip: got %h want 30", pkt_new_bip); end
    tick();
    dec_ready = 1'b0;
    #1;
    n_vec++; if (len_err !== 1'b1) begin n_err++; $display("FAIL lenerr_flag: got %b want 1", len_err); end
    n_vec++; if (pkt_old_bip !== 6'h30) begin n_err++; $display("FAIL lenerr_bip: got %h want 30", pkt_old_bip); end
    n_vec++; if (line_release !== 4'b0100) begin n_err++; $display("FAIL lenerr_release: got %b want 0100", line_release); end
    tick();
    n_vec++; if (len_err !== 1'b1) begin n_err++; $display("FAIL lenerr_sticky: got %b want 1", len_err); end
  endtask

  task automatic test_reset_mid();
    dec_ready = 1'b1; dec_length = 8'd16;
    tick();
    dec_ready = 1'b0;
    n_vec++; if (line_release !== 4'b1000) begin n_err++; $display("FAIL mid_release_pending: got %b want 1000", line_release); end
    reset = 1'b1;
    #1;
    n_vec++; if ((line_release !== 4'b0000) || (ibuf_flush !== 1'b0) || (pkt_valid !== 1'b0) || (len_err !== 1'b0) || (pkt_old_bip !== 6'h00))
      begin n_err++; $display("FAIL mid_reset_clear: got rel=%b flush=%b valid=%b err=%b bip=%h want all 0", line_release, ibuf_flush, pkt_valid, len_err, pkt_old_bip); end
    tick();
    reset = 1'b0;
    bp_valid = 1'b1; bp_bip = 6'h10;
    tick();
    tick();
    n_vec++; if ((pkt_valid !== 1'b0) || (ibuf_flush !== 1'b0) || (pkt_old_bip !== 6'h00))
      begin n_err++; $display("FAIL idle_ignores_bp: got valid=%b flush=%b bip=%h want 0/0/00", pkt_valid, ibuf_flush, pkt_old_bip); end
    bp_valid = 1'b0;
    init_valid = 1'b1; init_bip = 6'h10;
    tick();
    clear_inputs();
    #1;
    n_vec++; if ((ibuf_flush !== 1'b1) || (flush_line !== 2'd1) || (pkt_old_bip !== 6'h10) || (pkt_valid !== 1'b1))
      begin n_err++; $display("FAIL idle_init: got flush=%b line=%0d bip=%h valid=%b want 1/1/10/1", ibuf_flush, flush_line, pkt_old_bip, pkt_valid); end
  endtask

  task automatic test_random();
    bit m_active, m_err, redir, cov, pv, legal, e_flush;
    int m_bip, tgt, newb, adv;
    logic [NL-1:0] e_rel;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_active = 1'b0; m_err = 1'b0; m_bip = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NL; i++) lv[i] = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 7) == 0) ld[$urandom_range(0, NL*LB/4 - 1)*32 +: 32] = $urandom;
      init_valid    = ($urandom_range(0, 99) < 4);
      resteer_valid = ($urandom_range(0, 99) < 4);
      bp_valid      = ($urandom_range(0, 99) < 5);
      init_bip = BW'($urandom); resteer_bip = BW'($urandom); bp_bip = BW'($urandom);
      dec_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 9) == 0) dec_length = ($urandom_range(0, 1) == 0) ? 8'd0 : LW'($urandom_range(PB + 1, 255));
      else dec_length = LW'($urandom_range(1, PB));
      #1;
      redir = m_active ? (init_valid | resteer_valid | bp_valid) : init_valid;
      tgt   = init_valid ? int'(init_bip) : (resteer_valid ? int'(resteer_bip) : int'(bp_bip));
      cov   = exp_cov(m_bip, lv);
      pv    = m_active & cov & ~redir;
      legal = (dec_length >= 1) && (dec_length <= PB);
      adv   = legal ? int'(dec_length) : PB;
      newb  = (m_bip + adv) % WIN;
      n_vec++; if (pkt_valid !== pv) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, pkt_valid, pv); end
      n_vec++; if (pkt_old_bip !== BW'(m_bip)) begin n_err++; $display("FAIL rnd_old_bip@%0d: got %h want %h", cyc, pkt_old_bip, BW'(m_bip)); end
      n_vec++; if (pkt_new_bip !== BW'(newb)) begin n_err++; $display("FAIL rnd_new_bip@%0d: got %h want %h", cyc, pkt_new_bip, BW'(newb)); end
      n_vec++; if (pkt_data !== exp_pkt(m_bip)) begin n_err++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, pkt_data, exp_pkt(m_bip)); end
      e_flush = redir;
      e_rel   = 4'b0000;
      if (redir) begin
        m_bip = tgt;
        m_active = 1'b1;
      end else if (pv && dec_ready) begin
        if ((newb / LB) != (m_bip / LB)) e_rel[m_bip / LB] = 1'b1;
        if (!legal) m_err = 1'b1;
        m_bip = newb;
      end
      tick();
      n_vec++; if (ibuf_flush !== e_flush) begin n_err++; $display("FAIL rnd_flush@%0d: got %b want %b", cyc, ibuf_flush, e_flush); end
      if (e_flush) begin
        n_vec++; if (flush_line !== 2'(tgt / LB)) begin n_err++; $display("FAIL rnd_flush_line@%0d: got %0d want %0d", cyc, flush_line, tgt / LB); end
      end
      n_vec++; if (line_release !== e_rel) begin n_err++; $display("FAIL rnd_release@%0d: got %b want %b", cyc, line_release, e_rel); end
      n_vec++; if (len_err !== m_err) begin n_err++; $display("FAIL rnd_len_err@%0d: got %b want %b", cyc, len_err, m_err); end
    end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < NL*LB/4; i++) ld[i*32 +: 32] = $urandom;
    clear_inputs();
    lv = 4'b0000;
    reset = 1'b1;
    #2;
    test_reset();
    test_init_redirect();
    test_advance();
    test_wrap();
    test_redirect_priority();
    test_stall_len_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
